mem_wb_stage: RTL and testbench

//  Memory stage of the Y86-64 pipeline: consumes M-register outputs, runs the data-memory access over a req/ack

---
 rtl/y86_pkg.sv | 65 ++++++
 rtl/mem_wb_stage_w_reg.sv | 21 ++
 rtl/mem_wb_stage.sv | 156 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: instruction codes, status codes,
// the W-register payload and memory-op decode helpers.
package y86_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned NIB_W  = 4;

  localparam logic [NIB_W-1:0] IHALT   = 4'h0;
  localparam logic [NIB_W-1:0] INOP    = 4'h1;
  localparam logic [NIB_W-1:0] IRRMOVQ = 4'h2;
  localparam logic [NIB_W-1:0] IIRMOVQ = 4'h3;
  localparam logic [NIB_W-1:0] IRMMOVQ = 4'h4;
  localparam logic [NIB_W-1:0] IMRMOVQ = 4'h5;
  localparam logic [NIB_W-1:0] IOPQ    = 4'h6;
  localparam logic [NIB_W-1:0] IJXX    = 4'h7;
  localparam logic [NIB_W-1:0] ICALL   = 4'h8;
  localparam logic [NIB_W-1:0] IRET    = 4'h9;
  localparam logic [NIB_W-1:0] IPUSHQ  = 4'hA;
  localparam logic [NIB_W-1:0] IPOPQ   = 4'hB;

  localparam logic [NIB_W-1:0] SAOK = 4'h1;
  localparam logic [NIB_W-1:0] SHLT = 4'h2;
  localparam logic [NIB_W-1:0] SADR = 4'h3;
  localparam logic [NIB_W-1:0] SINS = 4'h4;

  localparam logic [NIB_W-1:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [NIB_W-1:0]  stat;
    logic [NIB_W-1:0]  icode;
    logic [NIB_W-1:0]  dst_e;
    logic [NIB_W-1:0]  dst_m;
    logic [WORD_W-1:0] val_e;
    logic [WORD_W-1:0] val_m;
  } w_bus_t;

  localparam w_bus_t W_NOP = '{
    stat:  SAOK,
    icode: INOP,
    dst_e: RNONE,
    dst_m: RNONE,
    val_e: '0,
    val_m: '0
  };

  function automatic logic is_mem_read(input logic [NIB_W-1:0] icode);
    return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
  endfunction

  function automatic logic is_mem_write(input logic [NIB_W-1:0] icode);
    return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
  endfunction

  // Stack pops address through valA (old %rsp); everything else uses valE.
  function automatic logic addr_from_val_a(input logic [NIB_W-1:0] icode);
    return (icode == IPOPQ) || (icode == IRET);
  endfunction

endpackage

// File: rtl/mem_wb_stage_w_reg.sv
// W pipeline register: hold on stall, load a nop on bubble, otherwise capture d.
module w_reg
  import y86_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   bubble,
  input  w_bus_t d,
  output w_bus_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= W_NOP;
    end else if (!stall) begin
      q <= bubble ? W_NOP : d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Y86-64 memory stage: issues data-memory accesses over req/ack and loads W.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYC cycles without ack.
module mem_wb_stage
  import y86_pkg::*;
#(
  parameter int unsigned DMEM_BYTES  = 8192,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        m_busy,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM
);

  localparam int unsigned ADDR_EXT_W = WORD_W + 1;

  mem_state_e        state;
  w_bus_t            pend;
  w_bus_t            w_in;
  w_bus_t            w_q;
  logic              is_mem;
  logic              is_wr;
  logic              in_range;
  logic              issue;
  logic [WORD_W-1:0] acc_addr;
  logic [NIB_W-1:0]  m_stat;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
`endif

  logic unused_cnd;
  assign unused_cnd = M_cnd;

  // Decode the M-register instruction and decide whether an access is issued.
  always_comb begin
    is_wr    = is_mem_write(M_icode);
    is_mem   = is_wr || is_mem_read(M_icode);
    acc_addr = addr_from_val_a(M_icode) ? M_valA : M_valE;
    in_range = (ADDR_EXT_W'(acc_addr) + ADDR_EXT_W'(8)) <= ADDR_EXT_W'(DMEM_BYTES);
    issue    = (state == MS_IDLE) && is_mem && (M_stat == SAOK) && in_range;
    m_stat   = (is_mem && (M_stat == SAOK) && !in_range) ? SADR : M_stat;
    m_busy   = issue || (state == MS_BUSY);
  end

  // W source: the finished memory instruction in DONE, else the live M register.
  always_comb begin
    w_in = '{stat: m_stat, icode: M_icode, dst_e: M_dstE, dst_m: M_dstM,
             val_e: M_valE, val_m: '0};
    if (state == MS_DONE) begin
      w_in = pend;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MS_IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      pend       <= W_NOP;
`ifdef MEM_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        MS_IDLE: begin
          if (issue) begin
            state      <= MS_BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= is_wr;
            dmem_addr  <= acc_addr;
            dmem_wdata <= M_valA;
            pend       <= '{stat: M_stat, icode: M_icode, dst_e: M_dstE,
                            dst_m: M_dstM, val_e: M_valE, val_m: '0};
`ifdef MEM_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end
        end
        MS_BUSY: begin
          if (dmem_ack) begin
            state      <= MS_DONE;
            dmem_req   <= 1'b0;
            pend.val_m <= dmem_rdata;
            if (dmem_err) begin
              pend.stat <= SADR;
            end
`ifdef MEM_TIMEOUT_EN
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            // No response in time: abandon the access and report an address fault.
            state      <= MS_DONE;
            dmem_req   <= 1'b0;
            pend.val_m <= '0;
            pend.stat  <= SADR;
          end else begin
            wait_cnt   <= wait_cnt + CNT_W'(1);
`endif
          end
        end
        MS_DONE: begin
          // A bubble replaces this cycle's W load, so the result waits another cycle.
          if (!W_stall && !W_bubble) begin
            state <= MS_IDLE;
          end
        end
        default: begin
          state    <= MS_IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

  w_reg u_w_reg (
    .clk    (clk),
    .rst    (rst),
    .stall  (W_stall),
    .bubble (W_bubble || m_busy),
    .d      (w_in),
    .q      (w_q)
  );

  assign W_stat  = w_q.stat;
  assign W_icode = w_q.icode;
  assign W_dstE  = w_q.dst_e;
  assign W_dstM  = w_q.dst_m;
  assign W_valE  = w_q.val_e;
  assign W_valM  = w_q.val_m;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; timeout checks need MEM_TIMEOUT_EN.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic [3:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        W_bubble;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        dmem_err;
  logic        m_busy;
  logic [3:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;

  int n_cmp = 0;
  int n_err = 0;

  mem_wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .M_stat     (M_stat),
    .M_icode    (M_icode),
    .M_cnd      (M_cnd),
    .M_valE     (M_valE),
    .M_valA     (M_valA),
    .M_dstE     (M_dstE),
    .M_dstM     (M_dstM),
    .W_stall    (W_stall),
    .W_bubble   (W_bubble),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .dmem_err   (dmem_err),
    .m_busy     (m_busy),
    .W_stat     (W_stat),
    .W_icode    (W_icode),
    .W_dstE     (W_dstE),
    .W_dstM     (W_dstM),
    .W_valE     (W_valE),
    .W_valM     (W_valM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [3:0] stat, input logic [3:0] icode, input logic [63:0] val_e,
                       input logic [63:0] val_a, input logic [3:0] dst_e, input logic [3:0] dst_m);
    M_stat  = stat;
    M_icode = icode;
    M_valE  = val_e;
    M_valA  = val_a;
    M_dstE  = dst_e;
    M_dstM  = dst_m;
  endtask

  task automatic set_nop();
    set_m(4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
  endtask

  initial begin
    rst = 1'b0;
    M_cnd = 1'b0;
    W_stall = 1'b0;
    W_bubble = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 64'h0;
    dmem_err = 1'b0;
    set_nop();
    #2 rst = 1'b1;
    repeat (2) tick();

    // reset state
    check("rst_req",   64'(dmem_req),   64'h0);
    check("rst_we",    64'(dmem_we),    64'h0);
    check("rst_addr",  dmem_addr,       64'h0);
    check("rst_wdata", dmem_wdata,      64'h0);
    check("rst_busy",  64'(m_busy),     64'h0);
    check("rst_icode", 64'(W_icode),    64'h1);
    check("rst_stat",  64'(W_stat),     64'h1);
    check("rst_dstE",  64'(W_dstE),     64'hF);
    check("rst_dstM",  64'(W_dstM),     64'hF);
    check("rst_valE",  W_valE,          64'h0);
    check("rst_valM",  W_valM,          64'h0);
    rst = 1'b0;
    tick();

    // 1: OPQ passes straight through
    set_m(4'h1, 4'h6, 64'h2A, 64'h0, 4'h3, 4'hF);
    #1 check("opq_busy", 64'(m_busy), 64'h0);
    tick();
    check("opq_valE",  W_valE,          64'h2A);
    check("opq_dstE",  64'(W_dstE),     64'h3);
    check("opq_icode", 64'(W_icode),    64'h6);
    check("opq_req",   64'(dmem_req),   64'h0);
    set_nop();

    // 2: MRMOVQ, ack one cycle after req
    set_m(4'h1, 4'h5, 64'h100, 64'h0, 4'hF, 4'h5);
    #1 check("rd_busy0", 64'(m_busy), 64'h1);
    tick();
    check("rd_req",   64'(dmem_req), 64'h1);
    check("rd_we",    64'(dmem_we),  64'h0);
    check("rd_addr",  dmem_addr,     64'h100);
    check("rd_busy1", 64'(m_busy),   64'h1);
    dmem_ack = 1'b1;
    dmem_rdata = 64'hDEAD;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 64'h0;
    check("rd_req_drop", 64'(dmem_req), 64'h0);
    check("rd_busy2",    64'(m_busy),   64'h0);
    check("rd_w_nop",    64'(W_icode),  64'h1);
    tick();
    check("rd_valM",  W_valM,        64'hDEAD);
    check("rd_dstM",  64'(W_dstM),   64'h5);
    check("rd_icode", 64'(W_icode),  64'h5);
    check("rd_stat",  64'(W_stat),   64'h1);
    set_nop();

    // 3: PUSHQ, ack after 4 cycles; request fields stay stable
    set_m(4'h1, 4'hA, 64'h1F8, 64'h55, 4'h4, 4'hF);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("wr_req",   64'(dmem_req), 64'h1);
      check("wr_we",    64'(dmem_we),  64'h1);
      check("wr_addr",  dmem_addr,     64'h1F8);
      check("wr_wdata", dmem_wdata,    64'h55);
      check("wr_busy",  64'(m_busy),   64'h1);
      if (i == 3) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    check("wr_req_drop", 64'(dmem_req), 64'h0);
    tick();
    check("wr_stat",  64'(W_stat),  64'h1);
    check("wr_icode", 64'(W_icode), 64'hA);
    check("wr_valE",  W_valE,       64'h1F8);
    set_nop();

    // 4: out-of-range address gives SADR without an access
    set_m(4'h1, 4'h4, 64'h2000, 64'h9, 4'hF, 4'hF);
    #1 check("oor_busy", 64'(m_busy), 64'h0);
    tick();
    check("oor_req",   64'(dmem_req), 64'h0);
    check("oor_stat",  64'(W_stat),   64'h3);
    check("oor_icode", 64'(W_icode),  64'h4);
    // last in-range address, access faults -> SADR
    set_m(4'h1, 4'h5, 64'h1FF8, 64'h0, 4'hF, 4'h6);
    #1 check("edge_busy", 64'(m_busy), 64'h1);
    tick();
    check("edge_addr", dmem_addr, 64'h1FF8);
    dmem_ack = 1'b1;
    dmem_err = 1'b1;
    dmem_rdata = 64'h1;
    tick();
    dmem_ack = 1'b0;
    dmem_err = 1'b0;
    dmem_rdata = 64'h0;
    tick();
    check("err_stat", 64'(W_stat), 64'h3);
    check("err_dstM", 64'(W_dstM), 64'h6);
    set_nop();
    // halted instruction passes status with no access
    set_m(4'h2, 4'h5, 64'h10, 64'h0, 4'hF, 4'h1);
    #1 check("hlt_busy", 64'(m_busy), 64'h0);
    tick();
    check("hlt_req",  64'(dmem_req), 64'h0);
    check("hlt_stat", 64'(W_stat),   64'h2);
    set_nop();

    // 5: W_stall for 3 cycles after ack keeps result pending
    set_m(4'h1, 4'h5, 64'h40, 64'h0, 4'hF, 4'h7);
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 64'h1234;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 64'h0;
    W_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_req",   64'(dmem_req), 64'h0);
      check("stl_busy",  64'(m_busy),   64'h0);
      check("stl_icode", 64'(W_icode),  64'h1);
    end
    W_stall = 1'b0;
    tick();
    check("stl_valM",  W_valM,        64'h1234);
    check("stl_icode_ld", 64'(W_icode), 64'h5);
    check("stl_dstM",  64'(W_dstM),   64'h7);
    set_nop();

    // POPQ addresses via valA; bubble in DONE inserts a nop first
    set_m(4'h1, 4'hB, 64'h88, 64'h80, 4'h4, 4'h2);
    tick();
    check("pop_addr", dmem_addr,   64'h80);
    check("pop_we",   64'(dmem_we), 64'h0);
    dmem_ack = 1'b1;
    dmem_rdata = 64'h77;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 64'h0;
    W_bubble = 1'b1;
    tick();
    W_bubble = 1'b0;
    check("bub_icode", 64'(W_icode),  64'h1);
    check("bub_req",   64'(dmem_req), 64'h0);
    tick();
    check("pop_valM",  W_valM,        64'h77);
    check("pop_valE",  W_valE,        64'h88);
    check("pop_icode", 64'(W_icode),  64'hB);
    set_nop();

`ifdef MEM_TIMEOUT_EN
    // 6a: no ack -> request abandoned after 16 busy cycles
    set_m(4'h1, 4'h5, 64'h200, 64'h0, 4'hF, 4'h3);
    tick();
    repeat (15) tick();
    check("to_req_hold", 64'(dmem_req), 64'h1);
    tick();
    check("to_req_drop", 64'(dmem_req), 64'h0);
    check("to_busy",     64'(m_busy),   64'h0);
    tick();
    check("to_stat", 64'(W_stat), 64'h3);
    check("to_valM", W_valM,      64'h0);
    set_nop();
`else
    // 6a: without the timeout the request waits for ack
    set_m(4'h1, 4'h5, 64'h200, 64'h0, 4'hF, 4'h3);
    tick();
    repeat (20) tick();
    check("nto_req_hold", 64'(dmem_req), 64'h1);
    dmem_ack = 1'b1;
    dmem_rdata = 64'h5A;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 64'h0;
    tick();
    check("nto_valM", W_valM, 64'h5A);
    set_nop();
`endif

    // 6b: async reset mid-access drops req at once and discards the result
    set_m(4'h1, 4'h5, 64'h300, 64'h0, 4'hF, 4'h8);
    tick();
    check("ar_req_pre", 64'(dmem_req), 64'h1);
    #2 rst = 1'b1;
    #1 check("ar_req", 64'(dmem_req), 64'h0);
    set_nop();
    tick();
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 64'hBAD;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 64'h0;
    tick();
    check("ar_req_post", 64'(dmem_req), 64'h0);
    check("ar_valM",     W_valM,        64'h0);
    check("ar_icode",    64'(W_icode),  64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
